fm_mot_mode_sequencer: RTL and testbench

- Selects the 2-bit `mode` that drives the FM MOT parameter-assignment block.
- Two control paths:
  - Manual: the mode follows the touchscreen selection.
  - Sequence: a triggered run through up to 4 programmed modes, each held for a programmed dwell.
- Every mode change is gated by `fm_idle` from FM_MOT, so parameters never switch mid-ramp.

---
 rtl/fm_mot_pkg.sv | 25 ++
 rtl/fm_seq_tick.sv | 45 ++++
 rtl/fm_mot_mode_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fm_mot_mode_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_mot_pkg.sv
// Shared definitions for the FM MOT mode sequencer: mode codes, sequencer
// states and the default width of the dwell/prescaler fields.
`timescale 1ns/1ps
package fm_mot_pkg;

  localparam int N_B_DEF = 16;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SAT    = 2'd1;
  localparam logic [1:0] MODE_FM326  = 2'd2;
  localparam logic [1:0] MODE_MOT361 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // A sequence counts as running only while it is arming or dwelling.
  function automatic logic seq_running(input seq_state_t s);
    return (s == ARM) || (s == DWELL);
  endfunction

endpackage

// File: rtl/fm_seq_tick.sv
// Dwell timer: a prescaler producing ticks every presc+1 cycles and a tick
// down-counter that flags the final cycle of a step's dwell.
`timescale 1ns/1ps
module fm_seq_tick
  import fm_mot_pkg::*;
#(
  parameter int N_B = N_B_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           en,
  input  logic [N_B-1:0] dwell,
  input  logic [N_B-1:0] presc,
  output logic           expire
);

  logic [N_B-1:0] cnt_reg;
  logic [N_B-1:0] pc_reg;
  logic           tick;

  // >= keeps the prescaler from running away if presc shrinks mid-tick.
  assign tick   = (pc_reg >= presc);
  assign expire = en && tick && (cnt_reg == N_B'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      pc_reg  <= '0;
    end else if (load) begin
      cnt_reg <= dwell;
      pc_reg  <= '0;
    end else if (en) begin
      if (tick) begin
        pc_reg <= '0;
        if (cnt_reg > N_B'(1)) begin
          cnt_reg <= cnt_reg - N_B'(1);
        end
      end else begin
        pc_reg <= pc_reg + N_B'(1);
      end
    end
  end

endmodule

// File: rtl/fm_mot_mode_sequencer.sv
// Mode selector for the FM MOT parameter block: manual touchscreen path plus a
// triggered multi-step sequence, with every mode change gated by fm_idle.
`timescale 1ns/1ps
module fm_mot_mode_sequencer
  import fm_mot_pkg::*;
#(
  parameter int N_B = N_B_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     manual_mode,
  input  logic           seq_en,
  input  logic           trig,
  input  logic [1:0]     nsteps,
  input  logic [1:0]     order_0,
  input  logic [1:0]     order_1,
  input  logic [1:0]     order_2,
  input  logic [1:0]     order_3,
  input  logic [N_B-1:0] dwell_0,
  input  logic [N_B-1:0] dwell_1,
  input  logic [N_B-1:0] dwell_2,
  input  logic [N_B-1:0] dwell_3,
  input  logic [N_B-1:0] presc,
  input  logic           fm_idle,
  output logic [1:0]     mode,
  output logic           mode_chg,
  output logic           busy,
  output logic [1:0]     step,
  output logic           switch_pend,
  output logic           done
);

  seq_state_t     state_reg, state_next;
  logic [1:0]     mode_reg, mode_next;
  logic [1:0]     step_reg, step_next;
  logic           trig_q_reg;
  logic           mode_chg_reg;
  logic           start;
  logic           load;
  logic           expire;
  logic           pend;
  logic           done_c;

  logic [1:0]     order_arr [4];
  logic [N_B-1:0] dwell_arr [4];
  logic [1:0]     cur_order;
  logic [N_B-1:0] cur_dwell;
  logic           skip_step;
  logic           last_step;

  assign order_arr[0] = order_0;
  assign order_arr[1] = order_1;
  assign order_arr[2] = order_2;
  assign order_arr[3] = order_3;
  assign dwell_arr[0] = dwell_0;
  assign dwell_arr[1] = dwell_1;
  assign dwell_arr[2] = dwell_2;
  assign dwell_arr[3] = dwell_3;

  assign cur_order = order_arr[step_reg];
  assign cur_dwell = dwell_arr[step_reg];
  assign skip_step = (cur_dwell == '0);
  assign last_step = (step_reg == nsteps);
  assign start     = trig && !trig_q_reg;

  fm_seq_tick #(
    .N_B (N_B)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (state_reg == DWELL),
    .dwell  (cur_dwell),
    .presc  (presc),
    .expire (expire)
  );

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    step_next  = step_reg;
    load       = 1'b0;
    pend       = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        pend = (manual_mode != mode_reg);
        // A start pre-empts the manual switch for this cycle.
        if (start && seq_en) begin
          step_next  = 2'd0;
          state_next = ARM;
        end else if (pend && fm_idle) begin
          mode_next = manual_mode;
        end
      end
      ARM: begin
        pend = !skip_step && (cur_order != mode_reg);
        if (!seq_en) begin
          step_next  = 2'd0;
          state_next = IDLE;
        end else if (skip_step) begin
          if (last_step) begin
            state_next = DONE;
          end else begin
            step_next = step_reg + 2'd1;
          end
        end else if (fm_idle || !pend) begin
          mode_next  = cur_order;
          load       = 1'b1;
          state_next = DWELL;
        end
      end
      DWELL: begin
        if (!seq_en) begin
          step_next  = 2'd0;
          state_next = IDLE;
        end else if (expire) begin
          if (last_step) begin
            state_next = DONE;
          end else begin
            step_next  = step_reg + 2'd1;
            state_next = ARM;
          end
        end
      end
      DONE: begin
        done_c     = 1'b1;
        step_next  = 2'd0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_OFF;
      step_reg     <= 2'd0;
      trig_q_reg   <= 1'b0;
      mode_chg_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      step_reg     <= step_next;
      trig_q_reg   <= trig;
      mode_chg_reg <= (mode_next != mode_reg);
    end
  end

  assign mode        = mode_reg;
  assign mode_chg    = mode_chg_reg;
  assign busy        = seq_running(state_reg);
  assign step        = step_reg;
  assign switch_pend = pend;
  assign done        = done_c;

endmodule

// File: tb/tb_fm_mot_mode_sequencer.sv
// Bench for fm_mot_mode_sequencer: cycle-level reference model compared every
// cycle, plus hand-derived cycle counts for each directed scenario.
`timescale 1ns/1ps
module tb_fm_mot_mode_sequencer;
  localparam int N_B = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     manual_mode;
  logic           seq_en;
  logic           trig;
  logic [1:0]     nsteps;
  logic [1:0]     order_a [4];
  logic [N_B-1:0] dwell_a [4];
  logic [N_B-1:0] presc;
  logic           fm_idle;
  logic [1:0]     mode;
  logic           mode_chg;
  logic           busy;
  logic [1:0]     step;
  logic           switch_pend;
  logic           done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fm_mot_mode_sequencer #(.N_B(N_B)) dut (
    .clk         (clk),
    .rst         (rst),
    .manual_mode (manual_mode),
    .seq_en      (seq_en),
    .trig        (trig),
    .nsteps      (nsteps),
    .order_0     (order_a[0]),
    .order_1     (order_a[1]),
    .order_2     (order_a[2]),
    .order_3     (order_a[3]),
    .dwell_0     (dwell_a[0]),
    .dwell_1     (dwell_a[1]),
    .dwell_2     (dwell_a[2]),
    .dwell_3     (dwell_a[3]),
    .presc       (presc),
    .fm_idle     (fm_idle),
    .mode        (mode),
    .mode_chg    (mode_chg),
    .busy        (busy),
    .step        (step),
    .switch_pend (switch_pend),
    .done        (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 manual, 1 waiting to apply a step, 2 dwelling,
  // 3 completion pulse. Dwell tracked as a plain remaining-cycle count.
  int m_phase, m_mode, m_step, m_left, m_old;
  bit m_chg, m_trig_q, m_valid = 0, m_start;

  function void model_step_end();
    if (m_step == int'(nsteps)) m_phase = 3;
    else begin
      m_step  = m_step + 1;
      m_phase = 1;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_mode = 0; m_step = 0; m_left = 0;
      m_chg = 0; m_trig_q = 0; m_valid = 1;
    end else begin
      m_old    = m_mode;
      m_start  = trig && !m_trig_q;
      m_trig_q = trig;
      case (m_phase)
        0: begin
          if (m_start && seq_en) begin
            m_step = 0; m_phase = 1;
          end else if (int'(manual_mode) != m_mode && fm_idle) begin
            m_mode = int'(manual_mode);
          end
        end
        1: begin
          if (!seq_en) begin
            m_phase = 0; m_step = 0;
          end else if (dwell_a[m_step] == 0) begin
            model_step_end();
          end else if (fm_idle || int'(order_a[m_step]) == m_mode) begin
            m_mode  = int'(order_a[m_step]);
            m_left  = int'(dwell_a[m_step]) * (int'(presc) + 1);
            m_phase = 2;
          end
        end
        2: begin
          if (!seq_en) begin
            m_phase = 0; m_step = 0;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) model_step_end();
          end
        end
        default: begin
          m_step = 0; m_phase = 0;
        end
      endcase
      m_chg = (m_mode != m_old);
    end
  end

  int exp_pend;
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_phase == 0) exp_pend = int'(int'(manual_mode) != m_mode);
      else if (m_phase == 1)
        exp_pend = int'(dwell_a[m_step] != 0 && int'(order_a[m_step]) != m_mode);
      else exp_pend = 0;
      chk("mode", int'(mode), m_mode);
      chk("step", int'(step), m_step);
      chk("mode_chg", int'(mode_chg), int'(m_chg));
      chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
      chk("done", int'(done), int'(m_phase == 3));
      chk("switch_pend", int'(switch_pend), exp_pend);
    end
  end

  // Per-scenario event counters for the hand-computed expectations.
  bit win = 0;
  bit prev_busy = 0;
  int n_mode [4];
  int n_busy, n_done, n_chg, n_start, n_pend0;
  always @(negedge clk) begin
    if (win) begin
      n_mode[mode] = n_mode[mode] + 1;
      if (busy) n_busy++;
      if (done) n_done++;
      if (mode_chg) n_chg++;
      if (busy && !prev_busy) n_start++;
      if (switch_pend && mode == 2'd0) n_pend0++;
    end
    prev_busy = busy;
  end

  task automatic clr();
    for (int k = 0; k < 4; k++) n_mode[k] = 0;
    n_busy = 0; n_done = 0; n_chg = 0; n_start = 0; n_pend0 = 0;
    win = 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1; cyc(1); trig = 1'b0;
  endtask

  task automatic wait_step1();
    int n = 0;
    while (step !== 2'd1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("wait_step1", int'(step), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout t=%0t got running expected finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; manual_mode = 2'd0; seq_en = 1'b0; trig = 1'b0;
    nsteps = 2'd0; presc = '0; fm_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      order_a[k] = 2'd0;
      dwell_a[k] = '0;
    end
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 0);

    // Manual path held off by fm_idle, then released.
    clr(); manual_mode = 2'd1; fm_idle = 1'b0;
    cyc(10);
    chk("man_pend_cycles", n_pend0, 10);
    fm_idle = 1'b1;
    cyc(3);
    chk("man_mode", int'(mode), 1);
    chk("man_chg_pulses", n_chg, 1);
    manual_mode = 2'd0;
    cyc(3);
    $display("manual switch: mode=%0d chg_pulses=%0d", mode, n_chg);

    // Three-step sequence: 10, 15, 5 dwell cycles.
    nsteps = 2'd2; presc = 16'd4; seq_en = 1'b1;
    order_a[0] = 2'd1; order_a[1] = 2'd2; order_a[2] = 2'd3;
    dwell_a[0] = 16'd2; dwell_a[1] = 16'd3; dwell_a[2] = 16'd1;
    clr(); pulse_trig(); cyc(60);
    chk("seq_mode1_cycles", n_mode[1], 11);
    chk("seq_mode2_cycles", n_mode[2], 16);
    chk("seq_mode3_cycles", n_mode[3], 7);
    chk("seq_busy_cycles", n_busy, 33);
    chk("seq_done_pulses", n_done, 1);
    chk("seq_chg_pulses", n_chg, 4);
    chk("seq_end_mode", int'(mode), 0);
    $display("sequence: m1=%0d m2=%0d m3=%0d busy=%0d", n_mode[1], n_mode[2], n_mode[3], n_busy);

    // Zero dwell skips step 1.
    dwell_a[1] = '0;
    clr(); pulse_trig(); cyc(50);
    chk("skip_mode1_cycles", n_mode[1], 12);
    chk("skip_mode2_cycles", n_mode[2], 0);
    chk("skip_mode3_cycles", n_mode[3], 7);
    chk("skip_busy_cycles", n_busy, 18);
    chk("skip_chg_pulses", n_chg, 3);
    dwell_a[1] = 16'd3;
    $display("skip: m1=%0d m2=%0d busy=%0d", n_mode[1], n_mode[2], n_busy);

    // fm_idle low for 7 cycles on entering step 1.
    clr(); pulse_trig(); wait_step1();
    fm_idle = 1'b0; cyc(7); fm_idle = 1'b1;
    cyc(50);
    chk("gate_mode1_cycles", n_mode[1], 18);
    chk("gate_mode2_cycles", n_mode[2], 16);
    chk("gate_busy_cycles", n_busy, 40);
    $display("gating: m1=%0d m2=%0d busy=%0d", n_mode[1], n_mode[2], n_busy);

    // Retrigger in DWELL ignored, then abort in step 1.
    clr(); pulse_trig(); cyc(5); pulse_trig();
    wait_step1(); cyc(3);
    seq_en = 1'b0; cyc(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_step", int'(step), 0);
    cyc(3);
    chk("abort_done_pulses", n_done, 0);
    chk("abort_starts", n_start, 1);
    seq_en = 1'b1;
    $display("abort: starts=%0d done=%0d", n_start, n_done);

    // trig held high starts exactly one run.
    clr(); trig = 1'b1; cyc(80);
    chk("held_starts", n_start, 1);
    chk("held_done_pulses", n_done, 1);
    trig = 1'b0; cyc(2);
    $display("held trig: starts=%0d done=%0d", n_start, n_done);

    // Reset in the middle of step 1's dwell.
    pulse_trig(); wait_step1(); cyc(3);
    chk("pre_rst_mode", int'(mode), 2);
    rst = 1'b1; cyc(1);
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_step", int'(step), 0);
    chk("rst_mid_chg", int'(mode_chg), 0);
    chk("rst_mid_done", int'(done), 0);
    rst = 1'b0; cyc(5);
    $display("mid-dwell reset: mode=%0d busy=%0d", mode, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
